// File: rtl/dcache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dcache_ctrl_pkg
// Purpose : FSM state encoding and address-field widths for the data cache.
// Rev     : 1.0  initial release
// ============================================================================
package dcache_ctrl_pkg;

  localparam int c_ADDR_BITS  = 32;
  localparam int c_DATA_BITS  = 32;
  localparam int c_INDEX_BITS = 4;
  localparam int c_WORD_BITS  = 2;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_REFILL = 2'd1;
  localparam logic [1:0] c_WRITE  = 2'd2;
  localparam logic [1:0] c_WDONE  = 2'd3;

  // Tag takes whatever is left above index, word offset and byte offset.
  function automatic int tagBits(input int indexBits, input int wordBits);
    return c_ADDR_BITS - indexBits - wordBits - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module  : dcache_array
// Purpose : Valid/tag/data storage, combinational read, synchronous write.
// Rev     : 1.0  initial release
// ============================================================================
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = c_INDEX_BITS,
  parameter int WORD_BITS  = c_WORD_BITS,
  parameter int TAG_BITS   = tagBits(c_INDEX_BITS, c_WORD_BITS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  rdIndex,
  input  logic [WORD_BITS-1:0]   rdWord,
  output logic                   rdValid,
  output logic [TAG_BITS-1:0]    rdTag,
  output logic [c_DATA_BITS-1:0] rdData,
  input  logic [INDEX_BITS-1:0]  wrIndex,
  input  logic [WORD_BITS-1:0]   wrWord,
  input  logic [c_DATA_BITS-1:0] wrData,
  input  logic                   wrEn,
  input  logic [TAG_BITS-1:0]    wrTag,
  input  logic                   tagWrEn
);

  localparam int c_LINES = 1 << INDEX_BITS;
  localparam int c_WORDS = 1 << WORD_BITS;

  logic [c_LINES-1:0]     r_valid;
  logic [TAG_BITS-1:0]    r_tag  [c_LINES];
  logic [c_DATA_BITS-1:0] r_data [c_LINES][c_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (tagWrEn) begin
      r_valid[wrIndex] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless while invalid, so they need no reset.
  always_ff @(posedge clk) begin
    if (tagWrEn) begin
      r_tag[wrIndex] <= wrTag;
    end
    if (wrEn) begin
      r_data[wrIndex][wrWord] <= wrData;
    end
  end

  assign rdValid = r_valid[rdIndex];
  assign rdTag   = r_tag[rdIndex];
  assign rdData  = r_data[rdIndex][rdWord];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dcache_ctrl
// Purpose : Direct-mapped write-through, no-write-allocate MEM-stage cache.
// Rev     : 1.0  initial release
// ============================================================================
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = c_INDEX_BITS,
  parameter int WORD_BITS  = c_WORD_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        hit,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memReady
);

  localparam int c_TAG_BITS = tagBits(INDEX_BITS, WORD_BITS);
  localparam logic [WORD_BITS-1:0] c_LAST_WORD = '1;

  logic [1:0]            r_state;
  logic [1:0]            w_nextState;
  logic [WORD_BITS-1:0]  r_count;

  logic [WORD_BITS-1:0]  w_word;
  logic [INDEX_BITS-1:0] w_index;
  logic [c_TAG_BITS-1:0] w_tag;
  logic                  w_unusedByteBits;

  logic                  w_rdValid;
  logic [c_TAG_BITS-1:0] w_rdTag;
  logic [31:0]           w_rdData;
  logic                  w_lookupHit;

  logic [WORD_BITS-1:0]  w_wrWord;
  logic [31:0]           w_wrData;
  logic                  w_dataWe;
  logic                  w_tagWe;

  assign w_word           = addr[WORD_BITS+1:2];
  assign w_index          = addr[WORD_BITS+INDEX_BITS+1:WORD_BITS+2];
  assign w_tag            = addr[31:WORD_BITS+INDEX_BITS+2];
  assign w_unusedByteBits = ^addr[1:0];

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .WORD_BITS  (WORD_BITS),
    .TAG_BITS   (c_TAG_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rdIndex (w_index),
    .rdWord  (w_word),
    .rdValid (w_rdValid),
    .rdTag   (w_rdTag),
    .rdData  (w_rdData),
    .wrIndex (w_index),
    .wrWord  (w_wrWord),
    .wrData  (w_wrData),
    .wrEn    (w_dataWe),
    .wrTag   (w_tag),
    .tagWrEn (w_tagWe)
  );

  assign w_lookupHit = w_rdValid && (w_rdTag == w_tag);

  always_comb begin
    w_nextState = r_state;
    hit         = 1'b0;
    readData    = '0;
    memReq      = 1'b0;
    memWe       = 1'b0;
    memAddr     = '0;
    memWData    = '0;
    w_wrWord    = w_word;
    w_wrData    = writeData;
    w_dataWe    = 1'b0;
    w_tagWe     = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (memWrite) begin
          w_nextState = c_WRITE;
        end else if (memRead) begin
          if (w_lookupHit) begin
            hit      = 1'b1;
            readData = w_rdData;
          end else begin
            w_nextState = c_REFILL;
          end
        end else begin
          hit = 1'b1;
        end
      end
      c_REFILL: begin
        memReq   = 1'b1;
        memAddr  = {w_tag, w_index, r_count, 2'b00};
        w_wrWord = r_count;
        w_wrData = memRData;
        if (memReady) begin
          w_dataWe = 1'b1;
          if (r_count == c_LAST_WORD) begin
            w_tagWe     = 1'b1;
            w_nextState = c_IDLE;
          end
        end
      end
      c_WRITE: begin
        memReq   = 1'b1;
        memWe    = 1'b1;
        memAddr  = {addr[31:2], 2'b00};
        memWData = writeData;
        if (memReady) begin
          // No allocate: only a line already holding this block is updated.
          w_dataWe    = w_lookupHit;
          w_nextState = c_WDONE;
        end
      end
      c_WDONE: begin
        hit         = 1'b1;
        w_nextState = c_IDLE;
      end
      default: w_nextState = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == c_IDLE) begin
        r_count <= '0;
      end else if (r_state == c_REFILL && memReady) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped data cache controller at the MEM stage, fed by the EX/MEM register outputs (memRead, memWrite, ALU result as address, readData2 as store data).
- Produces `hit`, which the EX/MEM register uses as its advance/stall enable.
- Refills lines from, and writes through to, a slow main memory using a req/ready handshake.
- Write-through, no-write-allocate, 4-word blocks.

Parameters:
- INDEX_BITS, 4, number of index bits; cache holds 2^INDEX_BITS lines.
- WORD_BITS, 2, word-offset bits; block holds 2^WORD_BITS 32-bit words.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- memRead  in  1  load request from EX/MEM.
- memWrite  in  1  store request from EX/MEM; wins if memRead is also high.
- addr  in  32  byte address; addr[1:0] ignored.
- writeData  in  32  store data.
- readData  out  32  load data; valid when hit=1 and memRead=1.
- hit  out  1  1 = access complete or no access (pipeline advances); 0 = stall.
- memReq  out  1  main-memory request.
- memWe  out  1  1 = write request, 0 = read request.
- memAddr  out  32  word-aligned memory address.
- memWData  out  32  memory write data.
- memRData  in  32  memory read data; valid when memReady=1.
- memReady  in  1  one-cycle acknowledge of the current request.

Behaviour:
- Address fields: word = addr[WORD_BITS+1:2]; index = next INDEX_BITS bits; tag = remaining upper bits.
- Storage: per line, a valid bit, a tag and 2^WORD_BITS data words. All valid bits are cleared by reset.
- States: IDLE, REFILL, WRITE, WDONE.
- IDLE:
  - No access: hit=1.
  - Read with valid and tag match: hit=1 combinationally; readData = stored word; no state change.
  - Read miss: hit=0; next state REFILL; refill counter = 0.
  - Write (hit or miss): hit=0; next state WRITE.
- REFILL:
  - Outputs: hit=0, memReq=1, memWe=0, memAddr = {tag, index, counter, 2'b00}.
  - On each memReady: store memRData into word[counter] and increment the counter.
  - On memReady with counter at its maximum: set valid, write the tag, go to IDLE. The next cycle re-looks up and hits.
  - Words are fetched in order 0..N-1; there is no critical-word-first.
- WRITE:
  - Outputs: hit=0, memReq=1, memWe=1, memAddr = addr with [1:0] cleared, memWData = writeData.
  - On memReady: if the line is valid and the tag matches, update the cached word; otherwise leave the cache unchanged (no allocate). Go to WDONE.
- WDONE:
  - hit=1 for exactly one cycle so EX/MEM advances; no new request is started.
  - Next state IDLE. This prevents the same store being issued twice.
- Request handshake: memReq, memWe, memAddr and memWData stay stable from assertion until memReady is sampled high. memReq is never asserted in IDLE or WDONE.
- Output defaults: memReq=0, memWe=0, memAddr=0, memWData=0. readData=0 whenever not (IDLE and read hit).
- Reset state: IDLE, all valid=0, counter=0.
- Reset mid-REFILL or mid-WRITE: abandon the operation; the line is not validated; memReq=0 in the cycle after the reset edge.
- memReady outside REFILL or WRITE is ignored.
- The inputs memRead, memWrite, addr and writeData are held stable by the stalled pipeline while hit=0. The controller does not latch them.
- Write hit to a line that is not the one being refilled is impossible: operations are serialised.

Decomposition:
- Shared package: state encoding (IDLE, REFILL, WRITE, WDONE) and the address-field width constants derived from INDEX_BITS and WORD_BITS.
- Natural sub-module: dcache_array, holding valid, tag and data storage with one read port and one write port (word write, plus tag/valid write), combinational read and synchronous write.
- The FSM, address slicing and memory handshake stay in dcache_ctrl.

Test Plan:
- Cold read of 0x40, memory responds after 2 cycles per word:
  - hit=0; memAddr sequence 0x40, 0x44, 0x48, 0x4C with memWe=0.
  - One cycle after the 4th memReady: hit=1 and readData = the value memory supplied for 0x40.
- After the refill, read 0x48: hit=1 in the same cycle, readData = the 0x48 refill word, memReq stays 0.
- Write 0xDEADBEEF to 0x48 (hit):
  - memReq=1, memWe=1, memAddr=0x48, memWData=0xDEADBEEF until memReady.
  - Then exactly one cycle of hit=1 (WDONE).
  - A following read of 0x48 returns 0xDEADBEEF with no memReq.
- Write to 0x1000 (miss): one memory write, then WDONE. A following read of 0x1000 misses and refills 0x1000–0x100C, confirming no allocate.
- Conflict: read 0x40, then read 0x440 (same index 4, different tag). 0x440 refills; a later read of 0x40 misses again.
- Assert rst after the 2nd refill word of 0x80: memReq=0 the next cycle. A read of 0x80 after reset misses and refills starting at word 0.
